// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the IF stage of the 16-bit THCO-MIPS pipeline.
// Holds the PC width, the default bubble instruction, the fetch FSM encoding and the fetch-response bundle.
package instruction_fetch_unit_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] instr;
    } fetch_rsp_t;

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// if_skid_buffer: 1-entry holding register for a fetch response that returns while IF/ID is stalled.
// Ports: clk, rst_n (async active-low), load/drain/clear controls, din/dout (fetch_rsp_t), full.
module if_skid_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       drain,
    input  logic       clear,
    input  fetch_rsp_t din,
    output fetch_rsp_t dout,
    output logic       full
);

    fetch_rsp_t data_q, data_d;
    logic       full_q, full_d;

    // clear (redirect) wins over load and drain
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            data_d = din;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/valid handshake (one outstanding) and fills IF/ID.
// Ports: clk, rst (async active-low), stall, redirect/redirect_pc, MemConflict,
//   im_req/im_addr/im_rdata/im_valid (instruction memory), if_pc/if_pc_next/if_instr/if_valid (IF/ID).
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt and perf_bubble_cnt outputs.
module instruction_fetch_unit #(
    parameter logic [15:0] START_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'h0001,
    parameter logic [15:0] NOP_INSTR = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        MemConflict,
    output logic        im_req,
    output logic [15:0] im_addr,
    input  logic [15:0] im_rdata,
    input  logic        im_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_next,
    output logic [15:0] if_instr,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    import instruction_fetch_unit_pkg::if_state_e;
    import instruction_fetch_unit_pkg::fetch_rsp_t;
    import instruction_fetch_unit_pkg::ST_IDLE;
    import instruction_fetch_unit_pkg::ST_REQ;
    import instruction_fetch_unit_pkg::ST_WAIT;
    import instruction_fetch_unit_pkg::ST_HOLD;

    if_state_e   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic [15:0] if_pc_next_q, if_pc_next_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        stale_q, stale_d;

    logic        skid_load, skid_drain, skid_clear, skid_full;
    fetch_rsp_t  skid_din, skid_dout;
    fetch_rsp_t  cons_src;
    logic        bubble, consume;

    if_skid_buffer u_skid (
        .clk   (clk),
        .rst_n (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .din   (skid_din),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides everything else
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (im_req) state_d = ST_WAIT;
            ST_WAIT: if (im_valid) state_d = (stall && !stale_q) ? ST_HOLD : ST_REQ;
            ST_HOLD: if (!stall) state_d = ST_REQ;
        endcase
        if (redirect) begin
            // an unreturned request keeps us in WAIT so its response can be dropped
            state_d = (state_q == ST_WAIT && !im_valid) ? ST_WAIT : ST_REQ;
        end
    end

    // Output and datapath logic
    always_comb begin
        // redirect masks the request so no response can land outside WAIT
        im_req  = (state_q == ST_REQ) && !MemConflict && !redirect;
        im_addr = pc_q;

        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_pc_next_d = if_pc_next_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;
        stale_d      = stale_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        skid_din     = '{pc: pc_q, instr: im_rdata};
        cons_src     = '{pc: pc_q, instr: im_rdata};
        bubble       = 1'b0;
        consume      = 1'b0;

        if (redirect) begin
            pc_d       = redirect_pc;
            bubble     = 1'b1;
            skid_clear = 1'b1;
            stale_d    = (state_q == ST_WAIT) && !im_valid;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_REQ: bubble = !stall;
                ST_WAIT: begin
                    if (im_valid && stale_q) begin
                        stale_d = 1'b0;
                        bubble  = !stall;
                    end else if (im_valid && !stall) begin
                        consume = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                    end else if (im_valid) begin
                        skid_load = 1'b1;
                    end else begin
                        bubble = !stall;
                    end
                end
                ST_HOLD: begin
                    if (!stall && skid_full) begin
                        consume    = 1'b1;
                        cons_src   = skid_dout;
                        skid_drain = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                    end
                end
            endcase
        end

        if (bubble) begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end
        if (consume) begin
            if_pc_d      = cons_src.pc;
            if_pc_next_d = cons_src.pc + PC_STEP;
            if_instr_d   = cons_src.instr;
            if_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= START_PC;
            if_pc_q      <= 16'h0000;
            if_pc_next_q <= 16'h0000;
            if_instr_q   <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_pc_next_q <= if_pc_next_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
            stale_q      <= stale_d;
        end
    end

    assign if_pc      = if_pc_q;
    assign if_pc_next = if_pc_next_q;
    assign if_instr   = if_instr_q;
    assign if_valid   = if_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, consume};
        bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit.
// A behavioural instruction memory answers requests; expected IF/ID contents are queued as fetches are set up.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        MemConflict = 1'b0;
    logic        im_req;
    logic [15:0] im_addr;
    logic [15:0] im_rdata = 16'h0000;
    logic        im_valid = 1'b0;
    logic [15:0] if_pc, if_pc_next, if_instr;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .MemConflict (MemConflict),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_valid    (im_valid),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .if_instr    (if_instr),
        .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h4801;
            16'h0001: return 16'h4901;
            16'h0006: return 16'hE82C;
            default:  return a ^ 16'h6A5C;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // memory model: latency counted in edges from acceptance
    int          mem_lat = 1;
    int          cnt = 0;
    logic [15:0] pend_addr = 16'h0000;

    always @(posedge clk) begin
        im_valid <= 1'b0;
        if (cnt == 1) begin
            im_valid <= 1'b1;
            im_rdata <= memval(pend_addr);
        end
        if (cnt > 0) cnt <= cnt - 1;
        if (im_req === 1'b1) begin
            if (mem_lat <= 1) begin
                im_valid <= 1'b1;
                im_rdata <= memval(im_addr);
            end else begin
                cnt       <= mem_lat - 1;
                pend_addr <= im_addr;
            end
        end
    end

    // output monitor: every newly loaded valid IF/ID entry must match the queue head
    logic        pv = 1'b0;
    logic [15:0] ppc = 16'h0000;
    logic [15:0] pins = 16'h0000;

    always @(negedge clk) begin
        if (!rst) begin
            pv <= 1'b0;
        end else begin
            if (if_valid && (!pv || if_pc != ppc || if_instr != pins)) begin
                chk("out_expected", 16'(sb.size() != 0), 16'h0001);
                if (sb.size() != 0) begin
                    automatic exp_t e = sb.pop_front();
                    chk("out_pc", if_pc, e.pc);
                    chk("out_instr", if_instr, e.instr);
                    chk("out_pc_next", if_pc_next, e.pc + 16'h0001);
                end
            end
            pv   <= if_valid;
            ppc  <= if_pc;
            pins <= if_instr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 16'(im_req), 16'h0000);
        chk("rst_instr", if_instr, 16'h0800);
        chk("rst_valid", 16'(if_valid), 16'h0000);
        chk("rst_pc", if_pc, 16'h0000);
        chk("rst_pc_next", if_pc_next, 16'h0000);

        // two sequential fetches, no hazards
        sb.push_back('{16'h0000, 16'h4801});
        sb.push_back('{16'h0001, 16'h4901});
        rst = 1'b1;
        @(negedge clk);
        chk("t1_req", 16'(im_req), 16'h0001);
        chk("t1_addr", im_addr, 16'h0000);
        @(negedge clk);
        chk("t1_wait_req", 16'(im_req), 16'h0000);
        @(negedge clk);
        chk("t1_i0", if_instr, 16'h4801);
        chk("t1_pc0", if_pc, 16'h0000);
        chk("t1_v0", 16'(if_valid), 16'h0001);
        @(negedge clk);
        chk("t1_bubble", 16'(if_valid), 16'h0000);
        @(negedge clk);
        chk("t1_i1", if_instr, 16'h4901);
        chk("t1_pc1", if_pc, 16'h0001);
        chk("t1_pcn1", if_pc_next, 16'h0002);
        chk("t1_addr2", im_addr, 16'h0002);
        MemConflict = 1'b1;

        // MemConflict for 3 cycles at pc=5
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0005;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mc_req", 16'(im_req), 16'h0000);
            chk("mc_addr", im_addr, 16'h0005);
            chk("mc_valid", 16'(if_valid), 16'h0000);
            chk("mc_instr", if_instr, 16'h0800);
            @(negedge clk);
        end
        MemConflict = 1'b0;
        #1;
        chk("mc_req_rel", 16'(im_req), 16'h0001);
        chk("mc_addr_rel", im_addr, 16'h0005);
        sb.push_back('{16'h0005, memval(16'h0005)});
        @(negedge clk);
        chk("t2_wait_req", 16'(im_req), 16'h0000);
        @(negedge clk);
        chk("t2_addr6", im_addr, 16'h0006);
        sb.push_back('{16'h0006, 16'hE82C});

        // stall coinciding with the response
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        chk("st_valid_a", 16'(if_valid), 16'h0000);
        chk("st_instr_a", if_instr, 16'h0800);
        chk("st_req_a", 16'(im_req), 16'h0000);
        @(negedge clk);
        chk("st_valid_b", 16'(if_valid), 16'h0000);
        chk("st_instr_b", if_instr, 16'h0800);
        chk("st_req_b", 16'(im_req), 16'h0000);
        stall = 1'b0;
        @(negedge clk);
        chk("st_instr", if_instr, 16'hE82C);
        chk("st_pc", if_pc, 16'h0006);
        chk("st_valid", 16'(if_valid), 16'h0001);
        chk("st_next_req", 16'(im_req), 16'h0001);
        chk("st_next_addr", im_addr, 16'h0007);

        // redirect while the addr-7 response is outstanding
        mem_lat = 3;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        chk("rd_req_a", 16'(im_req), 16'h0000);
        chk("rd_valid_a", 16'(if_valid), 16'h0000);
        @(negedge clk);
        chk("rd_req_b", 16'(im_req), 16'h0000);
        chk("rd_valid_b", 16'(if_valid), 16'h0000);
        mem_lat = 1;
        @(negedge clk);
        chk("rd_req", 16'(im_req), 16'h0001);
        chk("rd_addr", im_addr, 16'h0040);
        chk("rd_valid_c", 16'(if_valid), 16'h0000);
        chk("rd_instr_c", if_instr, 16'h0800);
        sb.push_back('{16'h0040, memval(16'h0040)});
        @(negedge clk);
        @(negedge clk);
        chk("rd_instr", if_instr, memval(16'h0040));
        chk("rd_pc", if_pc, 16'h0040);

        // PC wrap at 16'hFFFF
        MemConflict = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        MemConflict = 1'b0;
        #1;
        chk("wr_req", 16'(im_req), 16'h0001);
        chk("wr_addr", im_addr, 16'hFFFF);
        sb.push_back('{16'hFFFF, memval(16'hFFFF)});
        @(negedge clk);
        @(negedge clk);
        chk("wr_pc", if_pc, 16'hFFFF);
        chk("wr_pc_next", if_pc_next, 16'h0000);
        chk("wr_next_addr", im_addr, 16'h0000);
        chk("wr_next_req", 16'(im_req), 16'h0001);

        // reset in WAIT with a response pending; response lands in IDLE
        mem_lat = 2;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("r2_valid", 16'(if_valid), 16'h0000);
        chk("r2_req", 16'(im_req), 16'h0000);
        chk("r2_instr", if_instr, 16'h0800);
        chk("r2_pc", if_pc, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        chk("r2_first_req", 16'(im_req), 16'h0001);
        chk("r2_first_addr", im_addr, 16'h0000);
        chk("r2_valid_idle", 16'(if_valid), 16'h0000);
        sb.push_back('{16'h0000, 16'h4801});
        @(negedge clk);
        chk("r2_valid_wait", 16'(if_valid), 16'h0000);
        @(negedge clk);
        chk("r2_instr_out", if_instr, 16'h4801);
        chk("r2_valid_out", 16'(if_valid), 16'h0001);
        MemConflict = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory fetch interface. Sits at the IF stage of the 16-bit THCO-MIPS pipeline.
- Owns the PC and issues word addresses to instruction memory over a req/valid handshake with at most one fetch outstanding.
- Writes returned instructions into the IF/ID register.
- Honours pipeline stalls, branch redirects and MemConflict, the structural hazard where data memory owns the shared SRAM bus.

Parameters:
- START_PC, 16'h0000, PC value loaded at reset.
- PC_STEP, 1, increment between sequential fetches (word addressing).
- NOP_INSTR, 16'h0800, instruction placed into IF/ID for bubbles and flushes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold the IF/ID register and the PC.
- redirect  in  1  branch/jump resolved taken: squash and refetch.
- redirect_pc  in  16  target address for redirect.
- MemConflict  in  1  data memory owns the SRAM bus this cycle.
- im_req  out  1  fetch request.
- im_addr  out  16  fetch address; held stable while im_req=1.
- im_rdata  in  16  returned instruction.
- im_valid  in  1  im_rdata valid, one cycle per accepted request.
- if_pc  out  16  PC of the instruction in IF/ID.
- if_pc_next  out  16  if_pc + PC_STEP, used for link/branch arithmetic.
- if_instr  out  16  IF/ID instruction.
- if_valid  out  1  if_instr is a real fetched instruction.

Behaviour:
- Reset (rst=0, async): pc=START_PC, state=IDLE, im_req=0, if_instr=NOP_INSTR, if_valid=0, if_pc=0, if_pc_next=0, skid buffer empty, stale flag cleared.
- State IDLE (one cycle after reset release): any im_valid is ignored; next state is REQ.
- State REQ:
  - Drive im_req = ~MemConflict and im_addr = pc.
  - A request is accepted at a rising edge with im_req=1; the FSM then moves to WAIT.
  - If MemConflict=1, stay in REQ. If stall=0, IF/ID loads a bubble: if_instr=NOP_INSTR, if_valid=0.
- State WAIT:
  - im_req=0.
  - On im_valid: if stall=0, load IF/ID with {pc, pc+PC_STEP, im_rdata, valid=1}, advance pc += PC_STEP, go to REQ.
  - If stall=1 on im_valid: capture the response into a 1-entry skid buffer and go to HOLD.
  - Until im_valid arrives, IF/ID loads a bubble when stall=0.
- State HOLD:
  - Wait for stall=0, then move the skid entry to IF/ID, advance pc, go to REQ.
  - No request is issued while in HOLD.
- Latency: a fetch with 1-cycle memory and no hazards yields one instruction every 2 cycles (REQ, WAIT). Throughput optimisation is out of scope.
- Redirect:
  - Highest priority; overrides stall, MemConflict and im_valid.
  - Effects: pc=redirect_pc, IF/ID loads a bubble, skid buffer cleared.
  - If in WAIT with the response not yet returned, set the stale flag. Stay in WAIT, discard the next im_valid and clear the flag, then go to REQ.
  - If im_valid coincides with redirect, discard that response and go directly to REQ.
  - From REQ or HOLD, go to REQ next cycle with the new pc.
- Stall with no response pending: IF/ID holds its value and pc holds.
- PC arithmetic is 16-bit modulo: 16'hFFFF + 1 wraps to 16'h0000 with no error.
- im_addr must not change while im_req=1. A MemConflict deassertion mid-REQ re-presents the same address.

Optional Feature:
- IF_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] (accepted and consumed fetches) and perf_bubble_cnt[31:0] (bubble cycles into IF/ID). Both reset to 0 and wrap on overflow.
- When undefined, these ports and their logic are absent, and core behaviour is identical.

Decomposition:
- Shared package: NOP_INSTR, the PC width constant (16), the FSM state encoding (IDLE, REQ, WAIT, HOLD), and the fetch-response struct {pc, instr}.
- One sub-module: if_skid_buffer, a 1-entry holding register with load, drain and clear controls.
- The PC/FSM remains in the top module.

Test Plan:
- Reset release with a memory model returning 16'h4801 at addr 0 and 16'h4901 at addr 1, 1-cycle latency, no hazards -> if_instr=16'h4801, if_pc=0; two cycles later if_instr=16'h4901, if_pc=1, if_pc_next=2.
- MemConflict=1 for 3 cycles during REQ at pc=5 -> im_req=0 for 3 cycles; IF/ID shows NOP_INSTR with if_valid=0; then im_req=1 with im_addr=5 unchanged.
- stall=1 asserted in the cycle im_valid returns 16'hE82C -> IF/ID unchanged while stalled; one cycle after stall falls, if_instr=16'hE82C; no duplicate or lost fetch.
- redirect=1 with redirect_pc=16'h0040 while a response for addr 7 is outstanding -> the late im_valid is discarded; next im_addr=16'h0040; IF/ID contains a NOP bubble, never the addr-7 instruction.
- pc=16'hFFFF fetch completes -> next im_addr=16'h0000.
- rst asserted in WAIT with a response pending, and im_valid arriving in the IDLE cycle -> response ignored; first request goes to START_PC; if_valid=0 until that fetch returns.
